// File: rtl/nios_system_nios2_gen2_0_oci_dct_pkg.sv
// Shared constants and types for the OCI trace-atom packer.
// DCT_ATOM_W : bits per trace atom
// DCT_SLOTS  : atoms per packed word
// DCT_BUF_W  : packed word width
// DCT_CNT_W  : width of the atom-count field
// state_t    : packer FSM states
package nios_system_nios2_gen2_0_oci_dct_pkg;
  localparam int DCT_ATOM_W = 2;
  localparam int DCT_SLOTS  = 15;
  localparam int DCT_BUF_W  = DCT_ATOM_W * DCT_SLOTS;
  localparam int DCT_CNT_W  = 4;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ENDING = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/nios_system_nios2_gen2_0_oci_dct_outreg.sv
// Valid/ready holding register for packed trace words.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   load                : capture load_buffer/load_count and raise valid
//   load_buffer/count   : word to capture
//   take                : consumer accepts the held word
//   buffer/count/valid  : held word and its valid flag
//   free                : register can accept a load this cycle
module nios_system_nios2_gen2_0_oci_dct_outreg
  import nios_system_nios2_gen2_0_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [DCT_BUF_W-1:0] load_buffer,
  input  logic [DCT_CNT_W-1:0] load_count,
  input  logic                 take,
  output logic [DCT_BUF_W-1:0] buffer,
  output logic [DCT_CNT_W-1:0] count,
  output logic                 valid,
  output logic                 free
);
  // Free when empty or when the held word leaves on this edge.
  assign free = !valid || take;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buffer <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else if (load) begin
      // A load on the handshake edge keeps valid high: back-to-back words.
      buffer <= load_buffer;
      count  <= load_count;
      valid  <= 1'b1;
    end else if (take) begin
      valid  <= 1'b0;
    end
  end
endmodule

// File: rtl/nios_system_nios2_gen2_0_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit words (up to 15 atoms, first atom in
// the highest occupied slot) and hands them out over a valid/ready port.
// test_ending flushes any partial word and then parks the block in DONE.
// Optional macro OCI_DCT_TIMEOUT_EN: flush a partial word after
// TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   atom_valid/atom_data/ready   : atom input handshake
//   dct_buffer/count/valid/ready : packed word output handshake
//   test_ending                  : end-of-trace request (latched)
//   test_has_ended               : all atoms delivered (sticky)
module nios_system_nios2_gen2_0_oci_dct_packer
  import nios_system_nios2_gen2_0_oci_dct_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  atom_valid,
  input  logic [DCT_ATOM_W-1:0] atom_data,
  output logic                  atom_ready,
  output logic [DCT_BUF_W-1:0]  dct_buffer,
  output logic [DCT_CNT_W-1:0]  dct_count,
  output logic                  dct_valid,
  input  logic                  dct_ready,
  input  logic                  test_ending,
  output logic                  test_has_ended
);
  localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(DCT_SLOTS);

  logic [DCT_BUF_W-1:0] acc;
  logic [DCT_CNT_W-1:0] acc_count;
  state_t               state, state_nxt;
  logic                 free, full, xfer, accept, timeout;

  assign full   = (acc_count == FULL_CNT);
  assign xfer   = free && (full || (state == ENDING && acc_count != '0) || timeout);
  assign accept = atom_valid && atom_ready;

`ifdef OCI_DCT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] idle_cnt;

  // Counts idle cycles while a partial word sits in the accumulator; holds
  // at the limit until the output register frees up.
  always_ff @(posedge clk) begin
    if (!reset_n)                       idle_cnt <= '0;
    else if (accept || xfer)            idle_cnt <= '0;
    else if (acc_count != '0 && idle_cnt != TO_LAST) idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout = (acc_count != '0) && (idle_cnt == TO_LAST);
`else
  // Feature compiled out; the parameter stays referenced so both builds
  // share one interface.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Accumulator: shift left, newest atom in the low slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc       <= '0;
      acc_count <= '0;
    end else if (xfer) begin
      acc       <= '0;
      acc_count <= '0;
    end else if (accept) begin
      acc       <= {acc[DCT_BUF_W-DCT_ATOM_W-1:0], atom_data};
      acc_count <= acc_count + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= FILL;
    else          state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: if (test_ending) begin
        // Nothing captured and nothing pending: finish straight away.
        if (acc_count == '0 && !accept && free) state_nxt = DONE;
        else                                    state_nxt = ENDING;
      end
      ENDING: if (acc_count == '0 && free) state_nxt = DONE;
      DONE:   state_nxt = DONE;
      default: state_nxt = FILL;
    endcase
  end

  // FSM outputs; a transfer cycle never takes an atom.
  always_comb begin
    atom_ready     = (state == FILL) && !full && !xfer;
    test_has_ended = (state == DONE);
  end

  nios_system_nios2_gen2_0_oci_dct_outreg u_outreg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (xfer),
    .load_buffer (acc),
    .load_count  (acc_count),
    .take        (dct_ready),
    .buffer      (dct_buffer),
    .count       (dct_count),
    .valid       (dct_valid),
    .free        (free)
  );
endmodule

// File: tb/tb_nios_system_nios2_gen2_0_oci_dct_packer.sv
// Directed bench for the trace-atom packer. Build with or without
// OCI_DCT_TIMEOUT_EN; the idle-flush case adapts to the build.
module tb_nios_system_nios2_gen2_0_oci_dct_packer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_data = 2'd0;
  logic        atom_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready = 1'b0;
  logic        test_ending = 1'b0;
  logic        test_has_ended;

  int          errs = 0;
  int          nchk = 0;
  int          nwords = 0;
  logic [29:0] last_buf = '0;
  logic [3:0]  last_cnt = '0;
  logic        empty_seen = 1'b0;

  always #5 clk = ~clk;

  nios_system_nios2_gen2_0_oci_dct_packer #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  // Word log: a handshake seen mid-cycle completes on the next rising edge.
  always @(negedge clk) begin
    if (reset_n && dct_valid && dct_ready) begin
      nwords   <= nwords + 1;
      last_buf <= dct_buffer;
      last_cnt <= dct_count;
    end
    if (reset_n && dct_valid && dct_count == 4'd0) empty_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one atom and hold it until accepted (bounded).
  task automatic send(input logic [1:0] d);
    int w;
    w = 0;
    atom_valid = 1'b1;
    atom_data  = d;
    while (!atom_ready && w < 50) begin
      step();
      w++;
    end
    chk("atom_ready_wait", {31'd0, atom_ready}, 32'd1);
    step();
    atom_valid = 1'b0;
  endtask

  task automatic do_reset();
    atom_valid  = 1'b0;
    test_ending = 1'b0;
    dct_ready   = 1'b0;
    reset_n     = 1'b0;
    step(2);
    reset_n     = 1'b1;
  endtask

  initial begin
    int base;
    int k;

    // Reset state
    step(2);
    chk("rst_valid", {31'd0, dct_valid}, 32'd0);
    chk("rst_count", {28'd0, dct_count}, 32'd0);
    chk("rst_buffer", {2'd0, dct_buffer}, 32'd0);
    chk("rst_ended", {31'd0, test_has_ended}, 32'd0);
    reset_n = 1'b1;
    chk("rst_ready", {31'd0, atom_ready}, 32'd1);

    // Full word of 0,1,2,3,... with the consumer always ready
    dct_ready = 1'b1;
    base = nwords;
    for (int i = 0; i < 15; i++) send(2'(i % 4));
    chk("full_lat_n1", {31'd0, dct_valid}, 32'd0);
    step();
    chk("full_valid", {31'd0, dct_valid}, 32'd1);
    chk("full_count", {28'd0, dct_count}, 32'd15);
    chk("full_buffer", {2'd0, dct_buffer}, 32'h06C6C6C6);
    step();
    chk("full_drop", {31'd0, dct_valid}, 32'd0);
    chk("full_nwords", nwords, base + 1);

    // Backpressure: 30 atoms, consumer stalled, then back-to-back release
    dct_ready = 1'b0;
    base = nwords;
    for (int i = 0; i < 15; i++) send(2'd1);
    for (int i = 0; i < 15; i++) send(2'd2);
    chk("bp_ready_low", {31'd0, atom_ready}, 32'd0);
    chk("bp_valid", {31'd0, dct_valid}, 32'd1);
    chk("bp_buf1", {2'd0, dct_buffer}, 32'h15555555);
    step(18);
    chk("bp_hold_valid", {31'd0, dct_valid}, 32'd1);
    chk("bp_hold_buf", {2'd0, dct_buffer}, 32'h15555555);
    chk("bp_hold_cnt", {28'd0, dct_count}, 32'd15);
    dct_ready = 1'b1;
    step();
    chk("bp_b2b_valid", {31'd0, dct_valid}, 32'd1);
    chk("bp_buf2", {2'd0, dct_buffer}, 32'h2AAAAAAA);
    chk("bp_cnt2", {28'd0, dct_count}, 32'd15);
    step();
    chk("bp_drop", {31'd0, dct_valid}, 32'd0);
    chk("bp_nwords", nwords, base + 2);
    chk("bp_last_buf", {2'd0, last_buf}, 32'h2AAAAAAA);

    // Partial flush on test_ending, then sticky DONE
    do_reset();
    dct_ready = 1'b1;
    send(2'd3);
    send(2'd2);
    send(2'd1);
    test_ending = 1'b1;
    step();
    chk("end_pre_valid", {31'd0, dct_valid}, 32'd0);
    step();
    chk("end_valid", {31'd0, dct_valid}, 32'd1);
    chk("end_count", {28'd0, dct_count}, 32'd3);
    chk("end_buffer", {2'd0, dct_buffer}, 32'h39);
    chk("end_not_yet", {31'd0, test_has_ended}, 32'd0);
    step();
    chk("end_ended", {31'd0, test_has_ended}, 32'd1);
    chk("end_drop", {31'd0, dct_valid}, 32'd0);
    chk("end_ready0", {31'd0, atom_ready}, 32'd0);
    test_ending = 1'b0;
    atom_valid  = 1'b1;
    step(3);
    chk("end_sticky", {31'd0, test_has_ended}, 32'd1);
    chk("end_sticky_rdy", {31'd0, atom_ready}, 32'd0);
    chk("end_no_word", {31'd0, dct_valid}, 32'd0);
    atom_valid = 1'b0;

    // test_ending with nothing captured
    do_reset();
    test_ending = 1'b1;
    step();
    chk("idle_end_ended", {31'd0, test_has_ended}, 32'd1);
    chk("idle_end_valid", {31'd0, dct_valid}, 32'd0);
    test_ending = 1'b0;

    // Reset mid-operation with a held word and 7 atoms accumulated
    do_reset();
    for (int i = 0; i < 15; i++) send(2'd3);
    for (int i = 0; i < 7; i++) send(2'd1);
    chk("mid_pre_valid", {31'd0, dct_valid}, 32'd1);
    base = nwords;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_valid", {31'd0, dct_valid}, 32'd0);
    chk("mid_count", {28'd0, dct_count}, 32'd0);
    chk("mid_buffer", {2'd0, dct_buffer}, 32'd0);
    chk("mid_ended", {31'd0, test_has_ended}, 32'd0);
    chk("mid_ready", {31'd0, atom_ready}, 32'd1);
    dct_ready = 1'b1;
    step(20);
    chk("mid_quiet", {31'd0, dct_valid}, 32'd0);
    chk("mid_nwords", nwords, base);

    // Idle flush of a 2-atom partial word
    do_reset();
    dct_ready = 1'b1;
    base = nwords;
    send(2'd2);
    send(2'd1);
    k = 1;
    while (!dct_valid && k < 30) begin
      step();
      k++;
    end
`ifdef OCI_DCT_TIMEOUT_EN
    chk("to_latency_ok", {31'd0, (k >= 8 && k <= 9)}, 32'd1);
    chk("to_count", {28'd0, dct_count}, 32'd2);
    chk("to_buffer", {2'd0, dct_buffer}, 32'h9);
`else
    chk("no_to_valid", {31'd0, dct_valid}, 32'd0);
    chk("no_to_nwords", nwords, base);
`endif

    chk("no_empty_word", {31'd0, empty_seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
